// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM states,
// word geometry and the alignment/range check applied to every access.
package dmem_pkg;

  localparam int WORD_W     = 64;
  localparam int BYTE_OFF_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // The index is compared at full width so that large addresses cannot alias into the array.
  function automatic logic access_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    logic [WORD_W-1:0] idx;
    idx = {{BYTE_OFF_W{1'b0}}, addr[WORD_W-1:BYTE_OFF_W]};
    return (addr[BYTE_OFF_W-1:0] != '0) || (idx >= WORD_W'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage: synchronous write, registered read, zero at time 0.
// The read register holds its value until the next read strobe.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 128,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the CPU data-memory port: accepts one load/store, waits
// LATENCY cycles while stalling the pipeline, then presents the response.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_stall
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              err_q, err_d;
  logic              resp_err_q, resp_err_d;
  logic              rd_sel_q, rd_sel_d;

  logic              commit;
  logic              acc_write, acc_err;
  logic [AW-1:0]     acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic              mem_we, mem_re;
  logic [WORD_W-1:0] mem_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    err_d      = err_q;
    resp_err_d = resp_err_q;
    rd_sel_d   = rd_sel_q;
    commit     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;

    // With LATENCY==1 the commit happens on the acceptance edge, so use the live request.
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_err   = access_err(req_addr, DEPTH);
      acc_idx   = req_addr[BYTE_OFF_W +: AW];
      acc_wdata = req_wdata;
    end else begin
      acc_write = write_q;
      acc_err   = err_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[BYTE_OFF_W +: AW];
          wdata_d = req_wdata;
          write_d = req_write;
          err_d   = access_err(req_addr, DEPTH);
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d    = IDLE;
          resp_err_d = 1'b0;
          rd_sel_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      mem_we     = acc_write && !acc_err;
      mem_re     = !acc_write && !acc_err;
      resp_err_d = acc_err;
      rd_sel_d   = !acc_write && !acc_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      resp_err_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      err_q      <= err_d;
      resp_err_q <= resp_err_d;
      rd_sel_q   <= rd_sel_d;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (acc_idx),
    .wdata(acc_wdata),
    .rdata(mem_rdata)
  );

  // The array read register is not reset, so gate it with a resettable select.
  assign resp_rdata = rd_sel_q ? mem_rdata : '0;
  assign resp_err   = resp_err_q;
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign mem_stall  = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=3 and one
// at LATENCY=1, directed stimulus, monitors compare each response handshake.
module tb_data_mem_responder;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err, a_mem_stall;
  logic [63:0] a_req_addr, a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err, b_mem_stall;
  logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t qa[$];
  exp_t qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(128), .LATENCY(3)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_stall(a_mem_stall)
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_stall(b_mem_stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_resp_valid && a_resp_ready) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_resp: got rdata=%h err=%0d want none", a_resp_rdata, a_resp_err);
      end else begin
        e = qa.pop_front();
        $display("[cyc %0d] A resp rdata=%h err=%0d (exp %h/%0d)", cyc, a_resp_rdata, a_resp_err, e.rdata, e.err);
        chk("a_resp_rdata", a_resp_rdata, e.rdata);
        chk("a_resp_err", 64'(a_resp_err), 64'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_resp_valid && b_resp_ready) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_resp: got rdata=%h err=%0d want none", b_resp_rdata, b_resp_err);
      end else begin
        e = qb.pop_front();
        $display("[cyc %0d] B resp rdata=%h err=%0d (exp %h/%0d)", cyc, b_resp_rdata, b_resp_err, e.rdata, e.err);
        chk("b_resp_rdata", b_resp_rdata, e.rdata);
        chk("b_resp_err", 64'(b_resp_err), 64'(e.err));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic a_issue(input logic w, input logic [63:0] addr, input logic [63:0] wd,
                         input logic push, input logic [63:0] er, input logic ee, output int acc);
    bit got = 0;
    a_req_write = w;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_req_valid = 1'b1;
    if (push) qa.push_back('{rdata: er, err: ee});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_req_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL a_accept_timeout: got req_ready=0 want 1 within 40 cycles");
    end
    @(posedge clk);
    #1;
    acc = cyc;
    a_req_valid = 1'b0;
    $display("[cyc %0d] A req write=%0d addr=%h wdata=%h", acc, w, addr, wd);
  endtask

  task automatic a_wait_resp(input string tag);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk({tag, "_stall"}, 64'(a_mem_stall), 64'd1);
      if (a_resp_valid) break;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd2);
  endtask

  task automatic a_hold(input string tag, input int cycles, input logic [63:0] er, input logic ee);
    repeat (cycles) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 64'(a_resp_valid), 64'd1);
      chk({tag, "_hold_rdata"}, a_resp_rdata, er);
      chk({tag, "_hold_err"}, 64'(a_resp_err), 64'(ee));
      chk({tag, "_hold_ready"}, 64'(a_req_ready), 64'd0);
    end
  endtask

  task automatic a_handshake(input string tag, output int hs);
    @(posedge clk);
    #1;
    a_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    a_resp_ready = 1'b0;
    hs = cyc;
    chk({tag, "_post_valid"}, 64'(a_resp_valid), 64'd0);
    chk({tag, "_post_rdata"}, a_resp_rdata, 64'd0);
    chk({tag, "_post_err"}, 64'(a_resp_err), 64'd0);
    chk({tag, "_post_stall"}, 64'(a_mem_stall), 64'd0);
    chk({tag, "_post_ready"}, 64'(a_req_ready), 64'd1);
  endtask

  task automatic a_txn(input string tag, input logic w, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] er, input logic ee);
    int acc, hs;
    a_issue(w, addr, wd, 1'b1, er, ee, acc);
    a_wait_resp(tag);
    a_handshake(tag, hs);
  endtask

  initial begin
    int acc, hs, t5a, t5b;
    reset = 1'b1;
    {a_req_valid, a_req_write, a_resp_ready} = '0;
    {b_req_valid, b_req_write, b_resp_ready} = '0;
    a_req_addr = '0; a_req_wdata = '0;
    b_req_addr = '0; b_req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(a_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst_resp_rdata", a_resp_rdata, 64'd0);
    chk("rst_resp_err", 64'(a_resp_err), 64'd0);
    chk("rst_stall", 64'(a_mem_stall), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: store, latency and stall
    a_issue(1'b1, 64'h10, 64'hDEADBEEF_00000001, 1'b1, 64'd0, 1'b0, acc);
    a_wait_resp("t1");
    a_hold("t1", 1, 64'd0, 1'b0);
    a_handshake("t1", hs);

    // 2: read back, untouched word
    a_txn("t2_ld10", 1'b0, 64'h10, 64'd0, 64'hDEADBEEF_00000001, 1'b0);
    a_txn("t2_ld18", 1'b0, 64'h18, 64'd0, 64'd0, 1'b0);

    // 3: misaligned and out-of-range accesses
    a_txn("t3_ld13", 1'b0, 64'h13, 64'd0, 64'd0, 1'b1);
    a_txn("t3_st3f8", 1'b1, 64'h3F8, 64'h12345678_9ABCDEF0, 64'd0, 1'b0);
    a_txn("t3_st400", 1'b1, 64'h400, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 1'b1);
    a_txn("t3_st11", 1'b1, 64'h11, 64'h0000_0000_0000_0BAD, 64'd0, 1'b1);
    a_txn("t3_sthi", 1'b1, 64'h8000_0000_0000_0000, 64'h1111, 64'd0, 1'b1);
    a_txn("t3_ld3f8", 1'b0, 64'h3F8, 64'd0, 64'h12345678_9ABCDEF0, 1'b0);
    a_txn("t3_ld0", 1'b0, 64'h0, 64'd0, 64'd0, 1'b0);
    a_txn("t3_ld10", 1'b0, 64'h10, 64'd0, 64'hDEADBEEF_00000001, 1'b0);

    // 4: response back-pressure with a pending request
    a_issue(1'b0, 64'h10, 64'd0, 1'b1, 64'hDEADBEEF_00000001, 1'b0, acc);
    a_wait_resp("t4");
    @(posedge clk);
    #1;
    a_req_write = 1'b0;
    a_req_addr  = 64'h3F8;
    a_req_valid = 1'b1;
    a_hold("t4", 5, 64'hDEADBEEF_00000001, 1'b0);
    a_handshake("t4", hs);
    a_issue(1'b0, 64'h3F8, 64'd0, 1'b1, 64'h12345678_9ABCDEF0, 1'b0, acc);
    chk("t4_accept_edge", 64'(acc), 64'(hs + 1));
    a_wait_resp("t4b");
    a_handshake("t4b", hs);

    // 5: LATENCY=1 back-to-back store then load
    qb.push_back('{rdata: 64'd0, err: 1'b0});
    qb.push_back('{rdata: 64'h55, err: 1'b0});
    b_resp_ready = 1'b1;
    b_req_write  = 1'b1;
    b_req_addr   = 64'h8;
    b_req_wdata  = 64'h55;
    b_req_valid  = 1'b1;
    @(negedge clk);
    chk("t5_ready0", 64'(b_req_ready), 64'd1);
    @(posedge clk);
    #1;
    t5a = cyc;
    $display("[cyc %0d] B req write=1 addr=%h wdata=%h", t5a, 64'h8, 64'h55);
    b_req_write = 1'b0;
    b_req_wdata = '0;
    @(negedge clk);
    chk("t5_st_valid", 64'(b_resp_valid), 64'd1);
    chk("t5_st_ready", 64'(b_req_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_idle_valid", 64'(b_resp_valid), 64'd0);
    chk("t5_idle_ready", 64'(b_req_ready), 64'd1);
    @(posedge clk);
    #1;
    t5b = cyc;
    $display("[cyc %0d] B req write=0 addr=%h", t5b, 64'h8);
    b_req_valid = 1'b0;
    chk("t5_spacing", 64'(t5b - t5a), 64'd2);
    @(negedge clk);
    chk("t5_ld_valid", 64'(b_resp_valid), 64'd1);
    @(posedge clk);
    #1;
    b_resp_ready = 1'b0;
    @(negedge clk);
    chk("t5_end_valid", 64'(b_resp_valid), 64'd0);
    @(posedge clk);
    #1;

    // 6: asynchronous reset while a store is in BUSY
    a_issue(1'b1, 64'h20, 64'hAA, 1'b0, 64'd0, 1'b0, acc);
    @(negedge clk);
    chk("t6_busy_stall", 64'(a_mem_stall), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(a_req_ready), 64'd1);
    chk("t6_rst_valid", 64'(a_resp_valid), 64'd0);
    chk("t6_rst_rdata", a_resp_rdata, 64'd0);
    chk("t6_rst_err", 64'(a_resp_err), 64'd0);
    chk("t6_rst_stall", 64'(a_mem_stall), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    a_txn("t6_ld20", 1'b0, 64'h20, 64'd0, 64'd0, 1'b0);

    repeat (3) @(posedge clk);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
